// File: rtl/ci_sequencer.sv
// ci_sequencer: CI initiator, streams commands to a start/done slave and buffers results; perf counter under CI_SEQ_PERF_EN
module ci_sequencer #(
    parameter int DataWidth     = 32,
    parameter int ResultOpcode  = 4,
    parameter int ResultDepth   = 4,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic                 cmd_valid,
    output logic                 cmd_rdy,
    input  logic [2:0]           cmd_n,
    input  logic [DataWidth-1:0] cmd_data,
    output logic                 ci_clk_en,
    output logic                 ci_start,
    output logic [2:0]           ci_n,
    output logic [DataWidth-1:0] ci_dataa,
    input  logic                 ci_done,
    input  logic [DataWidth-1:0] ci_result,
    output logic                 res_valid,
    input  logic                 res_rdy,
    output logic [DataWidth-1:0] res_data,
    output logic                 err_timeout,
    output logic [31:0]          perf_cycles
);
    localparam int PW = $clog2(ResultDepth);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state_q, state_d;
    logic [2:0] ci_n_q, ci_n_d;
    logic [DataWidth-1:0] ci_dataa_q, ci_dataa_d;
    logic [7:0] tmo_q, tmo_d;
    logic err_q, err_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DataWidth-1:0] mem_q [ResultDepth];
    logic [DataWidth-1:0] mem_d [ResultDepth];
    logic busy, accept, push, pop, abort;

    assign busy        = state_q != IDLE;
    assign cmd_rdy     = clk_en && state_q == IDLE && cnt_q < CW'(ResultDepth);
    assign accept      = cmd_valid && cmd_rdy;
    assign push        = clk_en && busy && ci_done && ci_n_q == 3'(ResultOpcode);
    assign pop         = clk_en && res_valid && res_rdy;
    assign abort       = clk_en && busy && !ci_done && (tmo_q + 8'd1) == 8'(TimeoutCycles);
    assign ci_clk_en   = clk_en;
    assign ci_start    = clk_en && state_q == ISSUE;
    assign ci_n        = ci_n_q;
    assign ci_dataa    = ci_dataa_q;
    assign res_valid   = cnt_q != '0;
    assign res_data    = res_valid ? mem_q[rd_q] : '0;
    assign err_timeout = err_q;

    // Sequencer FSM: issue a latched command, then wait for done or timeout
    always_comb begin
        state_d    = state_q;
        ci_n_d     = ci_n_q;
        ci_dataa_d = ci_dataa_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d    = ISSUE;
                        ci_n_d     = cmd_n;
                        ci_dataa_d = cmd_data;
                        tmo_d      = '0;
                    end
                end
                default: begin
                    if (ci_done || abort) begin
                        state_d    = IDLE;
                        ci_n_d     = '0;
                        ci_dataa_d = '0;
                        err_d      = err_q | abort;
                    end else begin
                        state_d = WAIT;
                        tmo_d   = tmo_q + 8'd1;
                    end
                end
            endcase
        end
    end

    // Result FIFO bookkeeping; pushes only for the result opcode, pops gated by clk_en
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = ci_result;
            wr_d        = wr_q + PW'(1);
        end
        rd_d  = pop ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ci_n_q     <= '0;
            ci_dataa_q <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ci_n_q     <= ci_n_d;
            ci_dataa_q <= ci_dataa_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    // FIFO storage needs no reset: res_data is masked while empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef CI_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter, wraps at 2^32
    always_comb begin
        perf_d = (clk_en && busy) ? perf_q + 32'd1 : perf_q;
    end

    // Performance counter register
    always_ff @(posedge clk) begin
        if (reset) perf_q <= '0;
        else perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif
endmodule
